// File: rtl/uart_byte_rx.sv
//-----------------------------------------------------------------------------
// uart_byte_rx
//   8N1 serial byte receiver. The asynchronous line `rx` is synchronised,
//   start/data/stop bits are sampled at mid-bit, and each good byte is
//   presented as a one-cycle rx_flag strobe with the byte on rx_data.
//   A low stop bit gives a one-cycle frame_err strobe instead. After at least
//   one good byte, rx_idle pulses once when the line has stayed idle for
//   IDLE_BITS bit periods, which marks the end of a packet downstream.
//
// Ports
//   sys_clk    in   1  system clock
//   sys_rst_n  in   1  asynchronous active-low reset
//   rx         in   1  serial line, idle high, asynchronous to sys_clk
//   rx_data    out  8  last received byte (valid with rx_flag, held after)
//   rx_flag    out  1  one-cycle strobe: new byte on rx_data
//   frame_err  out  1  one-cycle strobe: stop bit sampled low
//   rx_idle    out  1  one-cycle strobe: line idle after >=1 byte
//-----------------------------------------------------------------------------
module uart_byte_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int IDLE_BITS = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_flag,
  output logic       frame_err,
  output logic       rx_idle
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE;
  localparam int BIT_MID      = BAUD_CNT_MAX / 2 - 1;
  localparam int IDLE_MAX     = IDLE_BITS * BAUD_CNT_MAX - 1;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] MID_CNT   = 16'(BIT_MID);
  localparam logic [23:0] IDLE_LAST = 24'(IDLE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic        rx_s_d;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [23:0] idle_cnt;
  logic        seen;
  logic        mid_bit;
  logic        start_edge;

  assign mid_bit    = (baud_cnt == MID_CNT);
  assign start_edge = (state == IDLE) && rx_s_d && !rx_s;

  // Two-flop synchroniser plus one extra delay for falling-edge detection.
  // Reset to the idle (high) line level so reset release is not an edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // Free-running bit-period counter, re-phased to the start edge so that
  // mid-bit samples land in the centre of every following bit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baud_cnt <= '0;
    end else if (start_edge || baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // Frame FSM with registered strobes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_flag   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_flag   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) state <= START;
        end
        START: begin
          if (mid_bit) begin
            if (rx_s) begin
              state <= IDLE;          // start bit did not last: glitch
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (mid_bit) begin
            shreg   <= {rx_s, shreg[7:1]};   // LSB arrives first
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (mid_bit) begin
            if (rx_s) begin
              rx_data <= shreg;
              rx_flag <= 1'b1;
              // Back to IDLE at mid stop bit so the next start edge can
              // follow with no gap.
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HI;
            end
          end
        end
        WAIT_HI: begin
          // A low line after a bad stop bit (e.g. break) must not be
          // mistaken for a new start bit; wait for it to go high first.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // End-of-packet detection: armed by a good byte, fires once after the
  // line has been continuously idle for IDLE_BITS bit periods.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt <= '0;
      seen     <= 1'b0;
      rx_idle  <= 1'b0;
    end else begin
      rx_idle <= 1'b0;
      if (state == STOP && mid_bit && rx_s) begin
        seen     <= 1'b1;             // same edge as rx_flag
        idle_cnt <= '0;
      end else if (state == IDLE && rx_s && seen) begin
        if (idle_cnt == IDLE_LAST) begin
          rx_idle  <= 1'b1;
          idle_cnt <= '0;
          seen     <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 24'd1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
//-----------------------------------------------------------------------------
// tb_uart_byte_rx
//   Directed bench for uart_byte_rx at default parameters (434 clocks/bit).
//   A negedge monitor records every strobe with its cycle number; each test
//   task drives the line and compares what it recorded to hand-computed
//   values.
//-----------------------------------------------------------------------------
module tb_uart_byte_rx;

  localparam int BIT      = 434;
  localparam int LATENCY  = 2 + 1 + 9 * 434 + 216 + 1;   // 4126
  localparam int FRAME    = 10 * 434;                    // 4340
  localparam int IDLE_DLY = 16 * 434;                    // 6944

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rx        = 1'b1;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       frame_err;
  logic       rx_idle;

  uart_byte_rx dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_flag   (rx_flag),
    .frame_err (frame_err),
    .rx_idle   (rx_idle)
  );

  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // strobe monitor
  logic [7:0] byte_q[$];
  int         flag_t[$];
  int         ferr_n  = 0;
  int         idle_n  = 0;
  int         idle_t  = 0;
  int         excl_n  = 0;

  always @(negedge sys_clk) begin
    if (rx_flag === 1'b1) begin
      byte_q.push_back(rx_data);
      flag_t.push_back(cyc);
    end
    if (frame_err === 1'b1) ferr_n = ferr_n + 1;
    if (rx_idle === 1'b1) begin
      idle_n = idle_n + 1;
      idle_t = cyc;
    end
    if ((rx_flag === 1'b1 && frame_err === 1'b1) ||
        (rx_idle === 1'b1 && (rx_flag === 1'b1 || frame_err === 1'b1)))
      excl_n = excl_n + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int last_fall = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Drives one frame starting at the current negedge; no trailing gap.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    last_fall = cyc;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(BIT);
    end
    rx = stop;
    tick(BIT);
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    tick(5);
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_cmp++; if (rx_flag !== 1'b0) begin n_err++; $display("FAIL reset_rx_flag: got %b expected 0", rx_flag); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_cmp++; if (rx_idle !== 1'b0) begin n_err++; $display("FAIL reset_rx_idle: got %b expected 0", rx_idle); end
    sys_rst_n = 1'b1;
    tick(20);
    $display("test_reset done");
  endtask

  task automatic test_single;
    int b, f;
    b = byte_q.size();
    f = ferr_n;
    send_byte(8'h55, 1'b1);
    tick(20);
    n_cmp++; if (byte_q.size() - b !== 1) begin n_err++; $display("FAIL single_count: got %0d expected 1", byte_q.size() - b); end
    if (byte_q.size() > b) begin
      n_cmp++; if (byte_q[b] !== 8'h55) begin n_err++; $display("FAIL single_data: got %h expected 55", byte_q[b]); end
      n_cmp++;
      if (flag_t[b] - last_fall < LATENCY - 2 || flag_t[b] - last_fall > LATENCY + 2) begin
        n_err++; $display("FAIL single_latency: got %0d expected %0d+/-2", flag_t[b] - last_fall, LATENCY);
      end
    end
    n_cmp++; if (ferr_n - f !== 0) begin n_err++; $display("FAIL single_ferr: got %0d expected 0", ferr_n - f); end
    $display("test_single: byte 55 sent");
  endtask

  task automatic test_back_to_back;
    int b;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'hA3;
    b = byte_q.size();
    for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1);
    tick(20);
    n_cmp++; if (byte_q.size() - b !== 3) begin n_err++; $display("FAIL b2b_count: got %0d expected 3", byte_q.size() - b); end
    if (byte_q.size() >= b + 3) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (byte_q[b+i] !== exp_b[i]) begin n_err++; $display("FAIL b2b_data%0d: got %h expected %h", i, byte_q[b+i], exp_b[i]); end
      end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (flag_t[b+i+1] - flag_t[b+i] < FRAME - 2 || flag_t[b+i+1] - flag_t[b+i] > FRAME + 2) begin
          n_err++; $display("FAIL b2b_spacing%0d: got %0d expected %0d+/-2", i, flag_t[b+i+1] - flag_t[b+i], FRAME);
        end
      end
    end
    $display("test_back_to_back: bytes 00 FF A3 sent");
  endtask

  task automatic test_glitch;
    int b, f;
    b = byte_q.size();
    f = ferr_n;
    rx = 1'b0;
    tick(100);
    rx = 1'b1;
    tick(600);
    n_cmp++; if (byte_q.size() - b !== 0) begin n_err++; $display("FAIL glitch_flag: got %0d expected 0", byte_q.size() - b); end
    n_cmp++; if (ferr_n - f !== 0) begin n_err++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_n - f); end
    send_byte(8'h3C, 1'b1);
    tick(20);
    n_cmp++;
    if (byte_q.size() - b !== 1 || byte_q[byte_q.size()-1] !== 8'h3C) begin
      n_err++; $display("FAIL glitch_next_byte: got count %0d last %h expected 1 / 3c", byte_q.size() - b, rx_data);
    end
    $display("test_glitch: 100-cycle glitch then byte 3c");
  endtask

  task automatic test_frame_err;
    int b, f;
    b = byte_q.size();
    f = ferr_n;
    send_byte(8'h81, 1'b0);
    tick(20 * BIT);
    n_cmp++; if (ferr_n - f !== 1) begin n_err++; $display("FAIL ferr_count: got %0d expected 1", ferr_n - f); end
    n_cmp++; if (byte_q.size() - b !== 0) begin n_err++; $display("FAIL ferr_no_flag: got %0d expected 0", byte_q.size() - b); end
    n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL ferr_data_held: got %h expected 3c", rx_data); end
    rx = 1'b1;
    tick(7200);
    n_cmp++;
    if (ferr_n - f !== 1 || byte_q.size() - b !== 0) begin
      n_err++; $display("FAIL ferr_after_high: got ferr %0d flags %0d expected 1 / 0", ferr_n - f, byte_q.size() - b);
    end
    $display("test_frame_err: byte 81 with low stop, break held");
  endtask

  task automatic test_idle;
    int b, i0, ft;
    b = byte_q.size();
    i0 = idle_n;
    send_byte(8'h12, 1'b1);
    tick(7000);
    n_cmp++;
    if (byte_q.size() - b !== 1 || byte_q[byte_q.size()-1] !== 8'h12) begin
      n_err++; $display("FAIL idle_byte: got count %0d data %h expected 1 / 12", byte_q.size() - b, rx_data);
    end
    n_cmp++; if (idle_n - i0 !== 1) begin n_err++; $display("FAIL idle_count: got %0d expected 1", idle_n - i0); end
    if (byte_q.size() > b && idle_n > i0) begin
      ft = flag_t[b];
      n_cmp++;
      if (idle_t - ft < IDLE_DLY - 2 || idle_t - ft > IDLE_DLY + 2) begin
        n_err++; $display("FAIL idle_timing: got %0d expected %0d+/-2", idle_t - ft, IDLE_DLY);
      end
    end
    tick(8000);
    n_cmp++; if (idle_n - i0 !== 1) begin n_err++; $display("FAIL idle_no_repeat: got %0d expected 1", idle_n - i0); end
    $display("test_idle: byte 12 then idle line");
  endtask

  task automatic test_reset_mid_frame;
    int b;
    logic [7:0] d;
    d = 8'hA5;
    b = byte_q.size();
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      tick(BIT);
    end
    rx = d[4];
    tick(200);
    sys_rst_n = 1'b0;
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
    n_cmp++; if (rx_flag !== 1'b0) begin n_err++; $display("FAIL midrst_rx_flag: got %b expected 0", rx_flag); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_frame_err: got %b expected 0", frame_err); end
    n_cmp++; if (rx_idle !== 1'b0) begin n_err++; $display("FAIL midrst_rx_idle: got %b expected 0", rx_idle); end
    @(negedge sys_clk);
    rx = 1'b1;
    tick(10);
    sys_rst_n = 1'b1;
    tick(50);
    n_cmp++; if (byte_q.size() - b !== 0) begin n_err++; $display("FAIL midrst_no_flag: got %0d expected 0", byte_q.size() - b); end
    send_byte(8'h7E, 1'b1);
    tick(20);
    n_cmp++;
    if (byte_q.size() - b !== 1 || byte_q[byte_q.size()-1] !== 8'h7E) begin
      n_err++; $display("FAIL midrst_next_byte: got count %0d data %h expected 1 / 7e", byte_q.size() - b, rx_data);
    end
    $display("test_reset_mid_frame: reset in bit 4, then byte 7e");
  endtask

  task automatic test_exclusive;
    n_cmp++; if (excl_n !== 0) begin n_err++; $display("FAIL strobe_overlap: got %0d expected 0", excl_n); end
    $display("test_exclusive: strobe overlap count checked");
  endtask

  initial begin
    @(negedge sys_clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_idle();
    test_reset_mid_frame();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
